// File: rtl/lf_approx_pkg.sv
// Shared definitions for the pipelined Ladner-Fischer approximate adder:
// operating-mode encoding and elaboration-time sizing helpers.
package lf_approx_pkg;

  // Per-beat operating mode; the encoding matches the in_approx pin.
  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  // Ceiling log2, used at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Number of prefix levels needed to combine WIDTH bit positions.
  function automatic int lf_levels(input int width);
    return (width <= 1) ? 0 : clog2(width);
  endfunction

endpackage

// File: rtl/lf_prefix_tree.sv
// Combinational Ladner-Fischer (minimum-depth) generate/propagate prefix
// network. It takes per-bit propagate/generate and a carry-in and produces
// the carry into every bit position, plus the carry out in c_o[WIDTH].
module lf_prefix_tree
  import lf_approx_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] p_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic             cin_i,
  output logic [WIDTH:0]   c_o
);

  localparam int LEVELS = lf_levels(WIDTH);

  logic [WIDTH-1:0] g_v;
  logic [WIDTH-1:0] p_v;

  // Prefix levels: at level lvl each bit in the upper half of a 2^(lvl+1)
  // block absorbs the group ending at the top of the lower half. Bits in the
  // lower half are untouched within a level, so updating in place is safe.
  always_comb begin
    // NOTE: every variable gets a full default before any conditional update;
    // a path that leaves a bit unassigned would infer a latch.
    g_v    = g_i;
    p_v    = p_i;
    // Folding the carry-in into bit 0 makes group-generate equal the carry.
    g_v[0] = g_i[0] | (p_i[0] & cin_i);
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> lvl) & 1) == 1) begin
          g_v[i] = g_v[i] | (p_v[i] & g_v[((i >> lvl) << lvl) - 1]);
          p_v[i] = p_v[i] & p_v[((i >> lvl) << lvl) - 1];
        end
      end
    end
  end

  // The carry into bit i+1 is the group generate over bits [i:0].
  assign c_o = {g_v, cin_i};

endmodule

// File: rtl/lf_approx_adder_pipe.sv
// Two-stage pipelined Ladner-Fischer adder with a per-beat exact/approximate
// mode, a valid/ready stream interface and an on-line error monitor.
// Stage 1 registers P/G, carry-in and mode. Stage 2 registers the sum, carry
// out, error flag and |exact - result|. Statistics update on output handshake.
module lf_approx_adder_pipe
  import lf_approx_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int K         = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_cin,
  input  logic                 in_approx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_cout,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]       err_max,
  input  logic                 stat_clr
);

  // Width of the exact upper part used in approximate mode.
  localparam int UW  = WIDTH - K;
  // Index of the top approximate bit, clamped so K=0 never forms index -1.
  localparam int KM1 = (K == 0) ? 0 : K - 1;
  // Selects the approximate lower part; all-zero when K=0, all-ones when K=WIDTH.
  localparam logic [WIDTH-1:0] LO_MASK = ~({WIDTH{1'b1}} << K);

  // Both stages advance together whenever the output register can be freed.
  logic en;
  logic out_hs;

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_p_q;
  logic [WIDTH-1:0] s1_g_q;
  logic             s1_cin_q;
  mode_e            s1_mode_q;

  // Stage 2 state and next-state
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_sum_q,  s2_sum_d;
  logic             s2_cout_q, s2_cout_d;
  logic             s2_err_q,  s2_err_d;
  logic [WIDTH:0]   s2_diff_q, s2_diff_d;

  // Statistics
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH:0]       err_max_q, err_max_d;

  // Stage 2 combinational datapath
  logic [WIDTH:0]   c_ex;
  logic [WIDTH-1:0] sum_ex;
  logic             cout_ex;
  logic [WIDTH-1:0] lo_carry;
  logic [WIDTH-1:0] lo_sum;
  logic [WIDTH-1:0] ap_sum_hi;
  logic             ap_cout;
  logic [WIDTH-1:0] ap_sum;
  logic [WIDTH:0]   ex_full;
  logic [WIDTH:0]   res_full;

  assign en       = !s2_valid_q || out_ready;
  assign in_ready = en;
  assign out_hs   = s2_valid_q && out_ready;

  // Stage 1 capture: bubbles enter as valid=0, the stage holds when stalled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of block evaluation order.
    // NOTE: the datapath registers are reset too, because out_sum/out_cout/
    // out_err must read zero after reset, not merely be qualified by valid.
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_p_q     <= '0;
      s1_g_q     <= '0;
      s1_cin_q   <= 1'b0;
      s1_mode_q  <= MODE_EXACT;
    end else if (en) begin
      s1_valid_q <= in_valid;
      s1_p_q     <= in_a ^ in_b;
      s1_g_q     <= in_a & in_b;
      s1_cin_q   <= in_cin;
      s1_mode_q  <= mode_e'(in_approx);
    end
  end

  // Full-width exact carry network.
  lf_prefix_tree #(.WIDTH(WIDTH)) u_exact_tree (
    .p_i  (s1_p_q),
    .g_i  (s1_g_q),
    .cin_i(s1_cin_q),
    .c_o  (c_ex)
  );

  assign sum_ex  = s1_p_q ^ c_ex[WIDTH-1:0];
  assign cout_ex = c_ex[WIDTH];

  // Approximate lower part: each carry is just the generate of the bit below,
  // with the external carry-in feeding bit 0.
  assign lo_carry = {s1_g_q[WIDTH-2:0], s1_cin_q};
  assign lo_sum   = s1_p_q ^ lo_carry;

  // Exact upper part, seeded with the generate of the top approximate bit.
  if (K < WIDTH) begin : g_upper
    logic        up_cin;
    logic [UW:0] up_c;

    assign up_cin = (K == 0) ? s1_cin_q : s1_g_q[KM1];

    lf_prefix_tree #(.WIDTH(UW)) u_upper_tree (
      .p_i  (s1_p_q[WIDTH-1:K]),
      .g_i  (s1_g_q[WIDTH-1:K]),
      .cin_i(up_cin),
      .c_o  (up_c)
    );

    assign ap_sum_hi = WIDTH'(s1_p_q[WIDTH-1:K] ^ up_c[UW-1:0]) << K;
    assign ap_cout   = up_c[UW];
  end else begin : g_no_upper
    // Whole word approximate: the carry out is the carry into bit WIDTH.
    assign ap_sum_hi = '0;
    assign ap_cout   = s1_g_q[KM1];
  end

  assign ap_sum = (lo_sum & LO_MASK) | ap_sum_hi;

  // Result select and error magnitude against the exact sum.
  always_comb begin
    s2_sum_d  = sum_ex;
    s2_cout_d = cout_ex;
    if (s1_mode_q == MODE_APPROX) begin
      s2_sum_d  = ap_sum;
      s2_cout_d = ap_cout;
    end
    ex_full   = {cout_ex, sum_ex};
    res_full  = {s2_cout_d, s2_sum_d};
    s2_diff_d = (ex_full >= res_full) ? (ex_full - res_full) : (res_full - ex_full);
    s2_err_d  = (s2_diff_d != '0);
  end

  // Stage 2 capture: result registers hold steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
      s2_cout_q  <= 1'b0;
      s2_err_q   <= 1'b0;
      s2_diff_q  <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_sum_q   <= s2_sum_d;
      s2_cout_q  <= s2_cout_d;
      s2_err_q   <= s2_err_d;
      s2_diff_q  <= s2_diff_d;
    end
  end

  // Statistics next-state: clear wins over a same-cycle handshake update.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_max_d = err_max_q;
    if (stat_clr) begin
      err_cnt_d = '0;
      err_max_d = '0;
    end else if (out_hs) begin
      if (s2_err_q && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
      if (s2_diff_q > err_max_q) begin
        err_max_d = s2_diff_q;
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
      err_max_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_max_q <= err_max_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_sum   = s2_sum_q;
  assign out_cout  = s2_cout_q;
  assign out_err   = s2_err_q;
  assign err_cnt   = err_cnt_q;
  assign err_max   = err_max_q;

endmodule
